// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: pad sync, deserialise, valid/ready write out.
// Optional readback path enabled by defining SPI_READBACK_EN.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ncs,
  input  logic              copi,
`ifdef SPI_READBACK_EN
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cipo,
`endif
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              overrun
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int PW        = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_q, ncs_q, copi_q;
  logic                   sclk_d, ncs_d;
  logic [PW-1:0]          prime_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [FRAME_LEN-1:0]   sh;

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, ncs_rise, ncs_fall;
  logic primed, shift_en, clr_cnt, err_ev;
  logic commit_wr, can_load;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_q[SYNC_STAGES-1];
  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign primed    = (prime_cnt == PW'(SYNC_STAGES));
  assign commit_wr = (state == COMMIT) && sh[FRAME_LEN-1];
  assign can_load  = !wr_valid || wr_ready;

  // Pad synchronisers plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      ncs_q  <= '1;
      copi_q <= '0;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ncs_q  <= {ncs_q[SYNC_STAGES-2:0], ncs};
      copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
      sclk_d <= sclk_s;
      ncs_d  <= ncs_s;
    end
  end

  // Sync outputs still hold reset values until the chain has refilled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prime_cnt <= '0;
    else if (!primed)
      prime_cnt <= prime_cnt + PW'(1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_n;
  end

  // Next-state and frame control
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    clr_cnt  = 1'b0;
    err_ev   = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        if (primed && ncs_s && ncs_d) state_n = IDLE;
      end
      IDLE: begin
        if (ncs_fall) begin
          clr_cnt = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          if (cnt == CNT_W'(FRAME_LEN)) begin
            state_n = COMMIT;
          end else begin
            err_ev  = 1'b1;
            state_n = IDLE;
          end
        end else if (sclk_rise && !ncs_s) begin
          shift_en = 1'b1;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = WAIT_IDLE;
    endcase
  end

  // Bit counter (saturating one past a full frame) and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (shift_en) begin
      sh <= {sh[FRAME_LEN-2:0], copi_s};
      if (cnt != CNT_W'(FRAME_LEN + 1)) cnt <= cnt + CNT_W'(1);
    end
  end

  // Write transaction register and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err_ev;
      overrun   <= commit_wr && !can_load;
      if (commit_wr && can_load) begin
        wr_valid <= 1'b1;
        wr_addr  <= sh[DATA_W +: ADDR_W];
        wr_data  <= sh[DATA_W-1:0];
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall, rd_hit, rd_load, rd_act;
  logic [DATA_W-1:0] rd_sh;

  assign sclk_fall = ~sclk_s & sclk_d;
  assign rd_hit    = shift_en && (cnt == CNT_W'(ADDR_W))
                     && !sh[ADDR_W-1];

  // Read address capture, then serialise rd_data on SCLK falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_load <= 1'b0;
      rd_act  <= 1'b0;
      rd_sh   <= '0;
      cipo    <= 1'b0;
    end else begin
      rd_load <= rd_hit;
      if (rd_hit) rd_addr <= {sh[ADDR_W-2:0], copi_s};
      if (ncs_rise) begin
        rd_act <= 1'b0;
        rd_sh  <= '0;
        cipo   <= 1'b0;
      end else if (rd_load) begin
        rd_act <= 1'b1;
        rd_sh  <= rd_data;
        cipo   <= rd_data[DATA_W-1];
      end else if (rd_act && sclk_fall && (state == SHIFT)
                   && (cnt >= CNT_W'(ADDR_W + 2))) begin
        rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
        cipo  <= rd_sh[DATA_W-2];
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: vector table plus corner sequences.
// Define SPI_READBACK_EN to also exercise the readback path.
module tb_spi_frame_rx;

  localparam int H   = 4;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst, sclk, ncs, copi, wr_ready;
  logic       wr_valid, frame_err, overrun;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
`ifdef SPI_READBACK_EN
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       cipo;
  logic [31:0] cap;
  logic [7:0]  rb_exp;
  assign rd_data = (rd_addr == 7'h05) ? 8'hA6 : 8'h00;
`endif

  spi_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi),
`ifdef SPI_READBACK_EN
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cipo      (cipo),
`endif
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         acc_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  int         rise_cyc = -100;
  logic       prev_v = 1'b0;
  logic [6:0] acc_addr = '0;
  logic [7:0] acc_data = '0;

  // Observe DUT outputs mid-cycle
  always @(negedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (wr_valid && wr_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_addr <= wr_addr;
      acc_data <= wr_data;
    end
    if (wr_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= wr_valid;
  end

  int total = 0, bad = 0;
  int ncs_rise_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] f, input int n,
                            input bit rdy_commit);
    ncs = 1'b0;
    wait_clk(H);
    for (int i = n - 1; i >= 0; i--) begin
      copi = f[i];
      wait_clk(H);
`ifdef SPI_READBACK_EN
      cap[n-1-i] = cipo;
`endif
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
    ncs = 1'b1;
    copi = 1'b0;
    ncs_rise_cyc = cyc;
    if (rdy_commit) begin
      wait_clk(LAT - 1);
      wr_ready = 1'b1;
      wait_clk(1);
      wr_ready = 1'b0;
    end
    wait_clk(12);
  endtask

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    int          exp_acc;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    int          exp_err;
  } vec_t;

  vec_t vt[7];
  int a0, e0, o0;

  initial begin
    vt[0] = '{32'h8155, 16, 1, 7'h01, 8'h55, 0};
    vt[1] = '{32'h0123, 16, 0, 7'h00, 8'h00, 0};
    vt[2] = '{32'h7FFF, 15, 0, 7'h00, 8'h00, 1};
    vt[3] = '{32'h1FFFF, 17, 0, 7'h00, 8'h00, 1};
    vt[4] = '{32'h0, 0, 0, 7'h00, 8'h00, 1};
    vt[5] = '{32'hFF80, 16, 1, 7'h7F, 8'h80, 0};
    vt[6] = '{32'h8000, 16, 1, 7'h00, 8'h00, 0};

    rst = 1'b1; sclk = 1'b0; ncs = 1'b1;
    copi = 1'b0; wr_ready = 1'b1;
    wait_clk(3);
    check("rst_valid", 32'(wr_valid), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    wait_clk(10);

    for (int k = 0; k < 7; k++) begin
      a0 = acc_cnt; e0 = err_cnt; o0 = ovr_cnt;
      send_frame(vt[k].frame, vt[k].nbits, 1'b0);
      check($sformatf("v%0d_acc", k), acc_cnt - a0, vt[k].exp_acc);
      check($sformatf("v%0d_err", k), err_cnt - e0, vt[k].exp_err);
      check($sformatf("v%0d_ovr", k), ovr_cnt - o0, 0);
      if (vt[k].exp_acc != 0) begin
        check($sformatf("v%0d_addr", k), 32'(acc_addr),
              32'(vt[k].exp_addr));
        check($sformatf("v%0d_data", k), 32'(acc_data),
              32'(vt[k].exp_data));
        check($sformatf("v%0d_lat", k), rise_cyc - ncs_rise_cyc, LAT);
      end
    end

    // Overrun: second write while first is still pending
    wr_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt;
    send_frame(32'h8233, 16, 1'b0);
    check("ov_valid", 32'(wr_valid), 1);
    check("ov_addr1", 32'(wr_addr), 32'h02);
    check("ov_data1", 32'(wr_data), 32'h33);
    send_frame(32'h8344, 16, 1'b0);
    check("ov_pulse", ovr_cnt - o0, 1);
    check("ov_addr2", 32'(wr_addr), 32'h02);
    check("ov_data2", 32'(wr_data), 32'h33);
    wr_ready = 1'b1;
    wait_clk(10);
    check("ov_acc", acc_cnt - a0, 1);
    check("ov_acc_data", 32'(acc_data), 32'h33);
    check("ov_drop", 32'(wr_valid), 0);

    // Ready coincides with commit of the next frame
    wr_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt;
    send_frame(32'h8611, 16, 1'b0);
    send_frame(32'h8722, 16, 1'b1);
    check("bb_ovr", ovr_cnt - o0, 0);
    check("bb_acc", acc_cnt - a0, 1);
    check("bb_acc_addr", 32'(acc_addr), 32'h06);
    check("bb_acc_data", 32'(acc_data), 32'h11);
    check("bb_valid", 32'(wr_valid), 1);
    check("bb_addr", 32'(wr_addr), 32'h07);
    check("bb_data", 32'(wr_data), 32'h22);
    wr_ready = 1'b1;
    wait_clk(5);
    check("bb_acc2", acc_cnt - a0, 2);
    check("bb_acc2_data", 32'(acc_data), 32'h22);

    // Reset in the middle of a frame with nCS held low
    a0 = acc_cnt; e0 = err_cnt;
    ncs = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
      end
      copi = i[0];
      wait_clk(H);
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
    ncs = 1'b1;
    wait_clk(12);
    check("mr_err", err_cnt - e0, 0);
    check("mr_acc", acc_cnt - a0, 0);
    send_frame(32'h8477, 16, 1'b0);
    check("mr_acc2", acc_cnt - a0, 1);
    check("mr_addr", 32'(acc_addr), 32'h04);
    check("mr_data", 32'(acc_data), 32'h77);
    check("mr_err2", err_cnt - e0, 0);

`ifdef SPI_READBACK_EN
    a0 = acc_cnt; e0 = err_cnt;
    rb_exp = 8'hA6;
    send_frame(32'h0500, 16, 1'b0);
    check("rb_addr", 32'(rd_addr), 32'h05);
    for (int b = 0; b < 8; b++)
      check($sformatf("rb_bit%0d", b + 8), 32'(cap[8+b]),
            32'(rb_exp[7-b]));
    check("rb_acc", acc_cnt - a0, 0);
    check("rb_err", err_cnt - e0, 0);
    check("rb_idle", 32'(cipo), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
